mod_counter: RTL and testbench

MOD_COUNTER -- requirements
Module: mod_counter

---
 rtl/mod_counter_pkg.sv | 38 +++
 rtl/mod_counter_if.sv | 25 ++
 rtl/mod_counter_prescale_tick.sv | 43 ++++
 rtl/mod_counter.sv | 106 ++++++++++
 tb/tb_mod_counter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo up/down counter: parameter defaults, direction and
// mode encodings, and elaboration-time legality helpers.
package mod_counter_pkg;

    localparam int unsigned DefWidth    = 7;
    localparam int unsigned DefModulus  = 128;
    localparam int unsigned DefPrescale = 1;

    typedef enum logic {
        DirDown = 1'b0,
        DirUp   = 1'b1
    } dir_e;

    typedef enum logic {
        ModeWrap = 1'b0,
        ModeSat  = 1'b1
    } mode_e;

    // Winning action at a clock edge once rst is out of the way.
    typedef enum logic [1:0] {
        OpHold,
        OpStep,
        OpLoad,
        OpClear
    } op_e;

    function automatic bit modulus_ok(int unsigned width, int unsigned modulus);
        if (width < 1 || width > 31) begin
            return 1'b0;
        end
        return (modulus >= 32'd2) && (64'(modulus) <= (64'd1 << width));
    endfunction

    function automatic bit prescale_ok(int unsigned prescale);
        return prescale >= 32'd1;
    endfunction

endpackage

// File: rtl/mod_counter_if.sv
// Control and status bundle of the modulo counter; the counter is the slave side.
interface mod_counter_if #(
    parameter int unsigned WIDTH = mod_counter_pkg::DefWidth
);

    logic             en;
    logic             up;
    logic             sat;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;

    modport master (
        output en, up, sat, clr, load, load_val,
        input  count, tc
    );

    modport slave (
        input  en, up, sat, clr, load, load_val,
        output count, tc
    );

endinterface

// File: rtl/mod_counter_prescale_tick.sv
// Enable prescaler: emits one tick per PRESCALE enabled cycles, no state when PRESCALE is 1.
module prescale_tick #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    if (PRESCALE <= 1) begin : g_bypass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst, clr};
        assign tick        = en;
    end else begin : g_count
        localparam int unsigned PhaseWidth = $clog2(PRESCALE);
        localparam logic [PhaseWidth-1:0] PhaseLast = PhaseWidth'(PRESCALE - 1);

        logic [PhaseWidth-1:0] phase_q;
        logic [PhaseWidth-1:0] phase_d;

        always_comb begin
            phase_d = phase_q;
            if (clr) begin
                phase_d = '0;
            end else if (en) begin
                phase_d = (phase_q == PhaseLast) ? '0 : phase_q + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_d;
            end
        end

        assign tick = en && (phase_q == PhaseLast);
    end

endmodule

// File: rtl/mod_counter.sv
// Modulo-MODULUS up/down counter with wrap or saturate mode, prescaled enable, clear and
// clamped load, plus a registered terminal-count pulse.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned MODULUS  = DefModulus,
    parameter int unsigned PRESCALE = DefPrescale
) (
    input logic          clk,
    input logic          rst,
    mod_counter_if.slave bus
);

    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("mod_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
    end
    if (!prescale_ok(PRESCALE)) begin : g_bad_prescale
        $error("mod_counter: PRESCALE %0d illegal", PRESCALE);
    end

    // One extra bit so MODULUS itself is representable when MODULUS == 2**WIDTH.
    localparam logic [WIDTH:0] ModulusExt = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0] ModLast    = ModulusExt - 1'b1;

    logic             tick;
    op_e              op;
    dir_e             dir;
    mode_e            mode;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] wrap_val;
    logic             at_bound;

    prescale_tick #(
        .PRESCALE(PRESCALE)
    ) u_prescale_tick (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr),
        .en  (bus.en),
        .tick(tick)
    );

    assign dir  = dir_e'(bus.up);
    assign mode = mode_e'(bus.sat);

    always_comb begin
        op = OpHold;
        if (bus.clr) begin
            op = OpClear;
        end else if (bus.load) begin
            op = OpLoad;
        end else if (tick) begin
            op = OpStep;
        end
    end

    always_comb begin
        cnt_ext  = {1'b0, count_q};
        load_ext = {1'b0, bus.load_val};
        step_ext = (dir == DirUp) ? cnt_ext + 1'b1 : cnt_ext - 1'b1;
        // Up boundary is reached when the incremented value would equal MODULUS.
        at_bound = (dir == DirUp) ? (step_ext == ModulusExt) : (count_q == '0);
        wrap_val = (dir == DirUp) ? '0 : ModLast[WIDTH-1:0];
        load_clamped = (load_ext >= ModulusExt) ? ModLast[WIDTH-1:0] : bus.load_val;
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        unique case (op)
            OpClear: count_d = '0;
            OpLoad:  count_d = load_clamped;
            OpStep: begin
                tc_d = at_bound;
                if (!at_bound) begin
                    count_d = step_ext[WIDTH-1:0];
                end else if (mode == ModeWrap) begin
                    count_d = wrap_val;
                end
            end
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: three configurations share one stimulus stream and are scored
// against an arithmetic reference model every cycle, plus directed checks.
module tb_mod_counter;

    typedef struct {
        int cnt;
        int ps;
        bit tc;
    } mstate_t;

    typedef struct {
        logic en;
        logic up;
        logic sat;
        logic clr;
        logic load;
        int   lv;
        int   exp_count;
        logic exp_tc;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       sat;
    logic       clr;
    logic       load;
    logic [6:0] lv;

    int n_tests;
    int n_fail;

    mstate_t ma;
    mstate_t mb;
    mstate_t mc;

    vec_t tbl[16];

    mod_counter_if #(.WIDTH(7)) if_a ();
    mod_counter_if #(.WIDTH(4)) if_b ();
    mod_counter_if #(.WIDTH(4)) if_c ();

    assign if_a.en = en;
    assign if_a.up = up;
    assign if_a.sat = sat;
    assign if_a.clr = clr;
    assign if_a.load = load;
    assign if_a.load_val = lv;
    assign if_b.en = en;
    assign if_b.up = up;
    assign if_b.sat = sat;
    assign if_b.clr = clr;
    assign if_b.load = load;
    assign if_b.load_val = lv[3:0];
    assign if_c.en = en;
    assign if_c.up = up;
    assign if_c.sat = sat;
    assign if_c.clr = clr;
    assign if_c.load = load;
    assign if_c.load_val = lv[3:0];

    mod_counter #(.WIDTH(7), .MODULUS(128), .PRESCALE(1)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a.slave)
    );
    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b.slave)
    );
    mod_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mstate_t model_next(mstate_t s, int modulus, int pre, int lvv);
        mstate_t n;
        bit      tick;
        n    = s;
        n.tc = 1'b0;
        if (rst || clr) begin
            n.cnt = 0;
            n.ps  = 0;
            return n;
        end
        tick = en && (s.ps == pre - 1);
        if (en) n.ps = tick ? 0 : s.ps + 1;
        if (load) begin
            n.cnt = (lvv >= modulus) ? modulus - 1 : lvv;
        end else if (tick) begin
            if (up) begin
                n.tc  = (s.cnt == modulus - 1);
                n.cnt = sat ? ((s.cnt + 1 > modulus - 1) ? modulus - 1 : s.cnt + 1)
                            : (s.cnt + 1) % modulus;
            end else begin
                n.tc  = (s.cnt == 0);
                n.cnt = sat ? ((s.cnt - 1 < 0) ? 0 : s.cnt - 1)
                            : (s.cnt - 1 + modulus) % modulus;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Advance one edge, update the model with the inputs seen at that edge, then score.
    task automatic cycle();
        @(posedge clk);
        ma = model_next(ma, 128, 1, int'(lv));
        mb = model_next(mb, 10, 3, int'(lv) % 16);
        mc = model_next(mc, 10, 1, int'(lv) % 16);
        #1;
        check("model_a_count", int'(if_a.count), ma.cnt);
        check("model_a_tc", int'(if_a.tc), int'(ma.tc));
        check("model_b_count", int'(if_b.count), mb.cnt);
        check("model_b_tc", int'(if_b.tc), int'(mb.tc));
        check("model_c_count", int'(if_c.count), mc.cnt);
        check("model_c_tc", int'(if_c.tc), int'(mc.tc));
    endtask

    task automatic set_in(input logic e, input logic u, input logic s, input logic c,
                          input logic l, input int v);
        en   = e;
        up   = u;
        sat  = s;
        clr  = c;
        load = l;
        lv   = 7'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 99);
        cycle();
        check("reset_a_count", int'(if_a.count), 0);
        check("reset_a_tc", int'(if_a.tc), 0);
        check("reset_b_count", int'(if_b.count), 0);
        rst = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        ma = '{cnt: 0, ps: 0, tc: 1'b0};
        mb = '{cnt: 0, ps: 0, tc: 1'b0};
        mc = '{cnt: 0, ps: 0, tc: 1'b0};
        rst = 1'b1;
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Saturate, clamp and priority vectors, checked on the MODULUS=10 PRESCALE=1 unit.
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2,  2, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0,  1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0,  0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0,  0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0,  0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0,  1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 15, 9, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0,  9, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5,  0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7,  7, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,  7, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0,  8, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,  7, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0,  0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,  9, 1'b1};

        // Default config: full 128-value wrap with a single tc pulse.
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 129; k++) begin
            cycle();
            check("wrap128_count", int'(if_a.count), k % 128);
            check("wrap128_tc", int'(if_a.tc), (k == 128) ? 1 : 0);
        end

        // Prescaled unit: one step every third enabled cycle, 9 -> 0 with tc.
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        for (int k = 1; k <= 31; k++) begin
            cycle();
            check("pre3_count", int'(if_b.count), (k / 3) % 10);
            check("pre3_tc", int'(if_b.tc), ((k % 3 == 0) && ((k / 3) % 10 == 0)) ? 1 : 0);
        end
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("pre3_hold_count", int'(if_b.count), 0);
            check("pre3_hold_tc", int'(if_b.tc), 0);
        end
        en = 1'b1;
        cycle();
        check("pre3_resume1", int'(if_b.count), 0);
        cycle();
        check("pre3_resume2", int'(if_b.count), 1);

        // Table-driven vectors.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_in(tbl[i].en, tbl[i].up, tbl[i].sat, tbl[i].clr, tbl[i].load, tbl[i].lv);
            cycle();
            check($sformatf("vec%0d_count", i), int'(if_c.count), tbl[i].exp_count);
            check($sformatf("vec%0d_tc", i), int'(if_c.tc), int'(tbl[i].exp_tc));
        end

        // Reset with load pending, mid-count and mid-prescale.
        do_reset();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        cycle();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 57);
        cycle();
        check("midrst_pre_count", int'(if_a.count), 57);
        rst = 1'b1;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 100);
        cycle();
        check("midrst_a_count", int'(if_a.count), 0);
        check("midrst_a_tc", int'(if_a.tc), 0);
        check("midrst_b_count", int'(if_b.count), 0);
        rst = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        cycle();
        check("midrst_b_step1", int'(if_b.count), 0);
        cycle();
        check("midrst_b_step2", int'(if_b.count), 0);
        cycle();
        check("midrst_b_step3", int'(if_b.count), 1);
        check("midrst_a_step3", int'(if_a.count), 3);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            rst  = ($urandom_range(0, 127) == 0);
            clr  = ($urandom_range(0, 47) == 0);
            load = ($urandom_range(0, 19) == 0);
            en   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) up = ~up;
            if ($urandom_range(0, 31) == 0) sat = ~sat;
            case ($urandom_range(0, 5))
                0:       lv = 7'd127;
                1:       lv = 7'd9;
                2:       lv = 7'd10;
                3:       lv = 7'd15;
                default: lv = 7'($urandom_range(0, 127));
            endcase
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
